// File: rtl/arm_regfile.sv
// Banked ARMv4 register file with CPSR/SPSR storage for the data-processing ALU.
// Holds the user bank R0-R15, the FIQ bank R8-R14, R13/R14 for irq/svc/abt/und
// and one SPSR for each exception mode. All reads are registered with latency 1.
// Exception entry saves CPSR, writes the target LR and switches mode in one edge.
module arm_regfile #(
  parameter logic [31:0] RESET_CPSR = 32'h0000_00D3,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_en,
  input  logic [3:0]  read_reg,
  output logic [31:0] read_value,
  input  logic        write_en,
  input  logic [3:0]  write_reg,
  input  logic [31:0] write_value,
  input  logic        write_restore_from_SPSR,
  input  logic        mode_read_en,
  output logic [31:0] mode_read_value,
  input  logic        cpsr_read_en,
  output logic [31:0] cpsr_read_value,
  input  logic        cpsr_write_en,
  input  logic [31:0] cpsr_write_value,
  input  logic        exc_en,
  input  logic [2:0]  exc_mode,
  input  logic [31:0] exc_lr,
  output logic [31:0] pc
);

  // mode_idx encoding used on mode_read_value and exc_mode
  localparam logic [2:0] MODE_USR = 3'd0;
  localparam logic [2:0] MODE_SYS = 3'd1;
  localparam logic [2:0] MODE_FIQ = 3'd2;
  localparam logic [2:0] MODE_IRQ = 3'd3;
  localparam logic [2:0] MODE_SVC = 3'd4;
  localparam logic [2:0] MODE_ABT = 3'd5;
  localparam logic [2:0] MODE_UND = 3'd6;

  // Unknown M[4:0] patterns behave as usr; the stored CPSR is left untouched.
  function automatic logic [2:0] mode_decode(input logic [4:0] m);
    case (m)
      5'b10000: mode_decode = MODE_USR;
      5'b11111: mode_decode = MODE_SYS;
      5'b10001: mode_decode = MODE_FIQ;
      5'b10010: mode_decode = MODE_IRQ;
      5'b10011: mode_decode = MODE_SVC;
      5'b10111: mode_decode = MODE_ABT;
      5'b11011: mode_decode = MODE_UND;
      default:  mode_decode = MODE_USR;
    endcase
  endfunction

  // M[4:0] pattern written into CPSR on exception entry.
  function automatic logic [4:0] mode_pattern(input logic [2:0] m);
    case (m)
      MODE_FIQ: mode_pattern = 5'b10001;
      MODE_IRQ: mode_pattern = 5'b10010;
      MODE_SVC: mode_pattern = 5'b10011;
      MODE_ABT: mode_pattern = 5'b10111;
      MODE_UND: mode_pattern = 5'b11011;
      default:  mode_pattern = 5'b10000;
    endcase
  endfunction

  // Physical storage
  logic [31:0] usr_q  [16];  // R0-R15 shared by usr and sys
  logic [31:0] fiq_q  [7];   // R8_fiq-R14_fiq
  logic [31:0] r13_q  [4];   // R13 for irq, svc, abt, und
  logic [31:0] r14_q  [4];   // R14 for irq, svc, abt, und
  logic [31:0] spsr_q [5];   // SPSR for fiq, irq, svc, abt, und
  logic [31:0] cpsr_q;
  logic [31:0] read_value_q;
  logic [31:0] mode_read_value_q;
  logic [31:0] cpsr_read_value_q;

  logic [2:0]  cur_mode;
  logic        cur_banked;   // irq/svc/abt/und: R13/R14 banked
  logic [2:0]  cur_bank;     // cur_mode - 3, selects r13_q/r14_q
  logic [2:0]  cur_spsr;     // cur_mode - 2, selects spsr_q
  logic [3:0]  rd_fiq_off;
  logic [3:0]  wr_fiq_off;
  logic        exc_valid;
  logic [2:0]  exc_bank;
  logic [2:0]  exc_spsr;
  logic [31:0] rd_data;
  logic [31:0] cpsr_d;

  assign cur_mode   = mode_decode(cpsr_q[4:0]);
  assign cur_banked = (cur_mode >= MODE_IRQ);
  assign cur_bank   = cur_mode - MODE_IRQ;
  assign cur_spsr   = cur_mode - MODE_FIQ;
  assign rd_fiq_off = read_reg - 4'd8;
  assign wr_fiq_off = write_reg - 4'd8;
  assign exc_valid  = exc_en && (exc_mode >= MODE_FIQ) && (exc_mode <= MODE_UND);
  assign exc_bank   = exc_mode - MODE_IRQ;
  assign exc_spsr   = exc_mode - MODE_FIQ;

  // Resolve the GPR read through the current mode's banking.
  always_comb begin
    // NOTE: default assignment first so every path drives rd_data and no latch is inferred.
    rd_data = usr_q[read_reg];
    if (cur_mode == MODE_FIQ && read_reg >= 4'd8 && read_reg <= 4'd14)
      rd_data = fiq_q[rd_fiq_off[2:0]];
    else if (cur_banked && read_reg == 4'd13)
      rd_data = r13_q[cur_bank[1:0]];
    else if (cur_banked && read_reg == 4'd14)
      rd_data = r14_q[cur_bank[1:0]];
  end

  // Next CPSR: exception entry beats SPSR restore beats a plain CPSR write.
  always_comb begin
    cpsr_d = cpsr_q;
    if (cpsr_write_en)
      cpsr_d = cpsr_write_value;
    if (write_en && write_restore_from_SPSR && cur_mode >= MODE_FIQ)
      cpsr_d = spsr_q[cur_spsr];
    if (exc_valid)
      cpsr_d = {cpsr_q[31:8], 1'b1, (exc_mode == MODE_FIQ) ? 1'b1 : cpsr_q[6],
                cpsr_q[5], mode_pattern(exc_mode)};
  end

  // Register file, PSR and read-port state update.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the architectural register file must come out of reset as zeros,
      // so every storage array is reset here rather than left uninitialised.
      for (int i = 0; i < 16; i++) usr_q[i] <= '0;
      for (int i = 0; i < 7; i++)  fiq_q[i] <= '0;
      for (int i = 0; i < 4; i++) begin
        r13_q[i] <= '0;
        r14_q[i] <= '0;
      end
      for (int i = 0; i < 5; i++)  spsr_q[i] <= '0;
      usr_q[15]         <= RESET_PC;
      cpsr_q            <= RESET_CPSR;
      read_value_q      <= '0;
      mode_read_value_q <= '0;
      cpsr_read_value_q <= '0;
    end else begin
      // NOTE: non-blocking updates mean reads here see pre-edge state, which
      // gives read-old-on-same-edge behaviour and lets the exc_lr write below
      // override a GPR write to the same register simply by coming later.
      if (read_en)      read_value_q      <= rd_data;
      if (mode_read_en) mode_read_value_q <= {29'b0, cur_mode};
      if (cpsr_read_en) cpsr_read_value_q <= cpsr_q;

      if (write_en) begin
        if (cur_mode == MODE_FIQ && write_reg >= 4'd8 && write_reg <= 4'd14)
          fiq_q[wr_fiq_off[2:0]] <= write_value;
        else if (cur_banked && write_reg == 4'd13)
          r13_q[cur_bank[1:0]] <= write_value;
        else if (cur_banked && write_reg == 4'd14)
          r14_q[cur_bank[1:0]] <= write_value;
        else
          usr_q[write_reg] <= write_value;
      end

      if (exc_valid) begin
        spsr_q[exc_spsr] <= cpsr_q;
        if (exc_mode == MODE_FIQ) fiq_q[6] <= exc_lr;
        else                      r14_q[exc_bank[1:0]] <= exc_lr;
      end

      cpsr_q <= cpsr_d;
    end
  end

  assign read_value      = read_value_q;
  assign mode_read_value = mode_read_value_q;
  assign cpsr_read_value = cpsr_read_value_q;
  assign pc              = usr_q[15];

endmodule
